// File: rtl/rot_arbiter_if.sv
// rtl/rot_arbiter_if.sv - request/response bundle between clients and the shared rotator
interface rot_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [32*NREQ-1:0]   req_data;
  logic [5*NREQ-1:0]    req_amount;
  logic [NREQ-1:0]      req_left;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [31:0]          rsp_data;
  logic                 busy;
  logic [15:0]          op_count;

  modport slave (
    input  req_valid, req_data, req_amount, req_left, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy, op_count
  );

  modport master (
    output req_valid, req_data, req_amount, req_left, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy, op_count
  );
endinterface

// File: rtl/rot_arbiter.sv
// rtl/rot_arbiter.sv - round-robin shared two-stage 32-bit barrel rotator
module rot_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  rot_arbiter_if.slave bus
);

  // S1: operand stage, S2: result stage
  logic            v1;
  logic [31:0]     s1_data;
  logic [4:0]      s1_amt;
  logic [IDW-1:0]  s1_id;
  logic            v2;
  logic [31:0]     s2_data;
  logic [IDW-1:0]  s2_id;

  logic [IDW-1:0]  ptr;
  logic [15:0]     op_cnt;

  logic            stall2;
  logic            adv1;
  logic            s1_open;
  logic            rsp_fire;
  logic            xfer;

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW:0]    cand;

  logic [31:0]     sel_data;
  logic [4:0]      sel_amt;
  logic            sel_left;
  logic [4:0]      eff_amt;
  logic [31:0]     rot_out;

  assign stall2   = v2 && !bus.rsp_ready;
  assign adv1     = v1 && !stall2;
  assign s1_open  = !v1 || adv1;
  assign rsp_fire = v2 && bus.rsp_ready;
  assign xfer     = |(bus.req_valid & bus.req_ready);

  // Search upward from the pointer with wrap; first valid requester wins
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // Grant only when S1 can take a new operand; held off while in reset
  always_comb begin
    bus.req_ready = '0;
    if (reset_n && s1_open && grant_found) begin
      bus.req_ready[grant_idx] = 1'b1;
    end
  end

  // Pick the granted requester's operand fields
  always_comb begin
    sel_data = '0;
    sel_amt  = '0;
    sel_left = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_data = bus.req_data[32*i +: 32];
        sel_amt  = bus.req_amount[5*i +: 5];
        sel_left = bus.req_left[i];
      end
    end
  end

  // Left rotation by n is right rotation by (32 - n) mod 32
  assign eff_amt = sel_left ? (5'd0 - sel_amt) : sel_amt;

  // Five right-rotate layers conditioned on the effective amount bits
  always_comb begin
    rot_out = s1_data;
    if (s1_amt[0]) rot_out = {rot_out[0],    rot_out[31:1]};
    if (s1_amt[1]) rot_out = {rot_out[1:0],  rot_out[31:2]};
    if (s1_amt[2]) rot_out = {rot_out[3:0],  rot_out[31:4]};
    if (s1_amt[3]) rot_out = {rot_out[7:0],  rot_out[31:8]};
    if (s1_amt[4]) rot_out = {rot_out[15:0], rot_out[31:16]};
  end

  // S1 loads on a transfer, empties when it advances without a refill
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v1      <= 1'b0;
      s1_data <= '0;
      s1_amt  <= '0;
      s1_id   <= '0;
    end else if (xfer) begin
      v1      <= 1'b1;
      s1_data <= sel_data;
      s1_amt  <= eff_amt;
      s1_id   <= grant_idx;
    end else if (adv1) begin
      v1      <= 1'b0;
    end
  end

  // S2 takes the rotated result on advance, clears when drained
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      v2      <= 1'b0;
      s2_data <= '0;
      s2_id   <= '0;
    end else if (adv1) begin
      v2      <= 1'b1;
      s2_data <= rot_out;
      s2_id   <= s1_id;
    end else if (rsp_fire) begin
      v2      <= 1'b0;
    end
  end

  // Pointer moves just past the winner on every transfer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + IDW'(1);
    end
  end

  // Completed-response counter, free-running wrap
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_cnt <= '0;
    end else if (rsp_fire) begin
      op_cnt <= op_cnt + 16'd1;
    end
  end

  assign bus.rsp_valid = v2;
  assign bus.rsp_data  = s2_data;
  assign bus.rsp_id    = s2_id;
  assign bus.busy      = v1 || v2;
  assign bus.op_count  = op_cnt;

endmodule

// File: tb/tb_rot_arbiter.sv
// tb/tb_rot_arbiter.sv - randomized and directed bench for rot_arbiter against a transaction model
module tb_rot_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  rot_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  rot_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int          id;
    logic [31:0] data;
    int          stage;
  } op_t;

  op_t q[$];
  int  m_ptr;
  int  m_count;
  int  n_checks;
  int  n_errors;
  logic [NREQ-1:0] obs_ready;
  int  obs_fire;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_rot(input logic [31:0] x, input int amt, input bit left);
    logic [63:0] w;
    w = {x, x};
    if (left) begin
      w = w << amt;
      return w[63:32];
    end
    w = w >> amt;
    return w[31:0];
  endfunction

  // One clock: compare against the model, then advance the model as the cycle edge would
  task automatic step();
    bit pres, stall, has1, can;
    int g;
    logic [NREQ-1:0] exp_ready;
    op_t op;
    #1;
    pres = (q.size() > 0) && (q[0].stage == 2);
    check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(pres));
    if (pres) begin
      check_eq("rsp_data", bus.rsp_data, q[0].data);
      check_eq("rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
    end
    check_eq("busy", 32'(bus.busy), 32'(q.size() > 0));
    check_eq("op_count", 32'(bus.op_count), 32'(m_count));
    stall = pres && !bus.rsp_ready;
    has1  = (q.size() > 0) && (q[q.size()-1].stage == 1);
    can   = !has1 || !stall;
    g = -1;
    if (can) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && bus.req_valid[idx]) g = idx;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check_eq("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    obs_ready = bus.req_ready;
    obs_fire  = (bus.rsp_valid && bus.rsp_ready) ? 1 : 0;
    if (pres && bus.rsp_ready) begin
      void'(q.pop_front());
      m_count = (m_count + 1) % 65536;
    end
    if (!stall) begin
      foreach (q[i]) q[i].stage = 2;
    end
    if (g >= 0) begin
      op.id    = g;
      op.data  = ref_rot(bus.req_data[32*g +: 32], int'(bus.req_amount[5*g +: 5]), bus.req_left[g]);
      op.stage = 1;
      q.push_back(op);
      m_ptr = (g + 1) % NREQ;
    end
    @(negedge clock);
  endtask

  // Called at a falling edge; returns one cycle later with reset released
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_op_count", 32'(bus.op_count), 32'd0);
    check_eq("rst_rsp_data", bus.rsp_data, 32'd0);
    check_eq("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    q.delete();
    m_ptr   = 0;
    m_count = 0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic drive_random();
    bus.req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
    for (int i = 0; i < NREQ; i++) begin
      bus.req_data[32*i +: 32] = $urandom;
      bus.req_amount[5*i +: 5] = 5'($urandom_range(0, 31));
      bus.req_left[i]          = 1'($urandom_range(0, 1));
    end
    bus.rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    int acc;
    int fires;
    n_checks = 0;
    n_errors = 0;
    m_ptr    = 0;
    m_count  = 0;
    bus.req_valid  = '1;
    bus.req_data   = '0;
    bus.req_amount = '0;
    bus.req_left   = '0;
    bus.rsp_ready  = 1'b1;

    @(negedge clock);
    do_reset();

    // single right rotate by 1 from requester 0
    bus.req_valid = 4'b0001;
    bus.req_data[31:0] = 32'h0000_0001;
    bus.req_amount[4:0] = 5'd1;
    bus.req_left[0] = 1'b0;
    step();
    bus.req_valid = '0;
    step();
    #1;
    check_eq("single_valid", 32'(bus.rsp_valid), 32'd1);
    check_eq("single_data", bus.rsp_data, 32'h8000_0000);
    check_eq("single_id", 32'(bus.rsp_id), 32'd0);
    step();
    #1;
    check_eq("single_count", 32'(bus.op_count), 32'd1);

    // left rotates from requester 2, amounts 4 and 0
    bus.req_valid = 4'b0100;
    bus.req_data[95:64] = 32'h1234_5678;
    bus.req_amount[14:10] = 5'd4;
    bus.req_left[2] = 1'b1;
    step();
    bus.req_amount[14:10] = 5'd0;
    step();
    bus.req_valid = '0;
    #1;
    check_eq("left4_data", bus.rsp_data, 32'h2345_6781);
    step();
    #1;
    check_eq("left0_data", bus.rsp_data, 32'h1234_5678);
    step();
    step();

    // round robin from a fresh pointer
    do_reset();
    bus.req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NREQ; i++) bus.req_data[32*i +: 32] = $urandom;
      #1;
      check_eq("rr_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
      if (k >= 2) check_eq("rr_id", 32'(bus.rsp_id), 32'((k - 2) % 4));
      step();
    end
    bus.req_valid = '0;
    for (int k = 0; k < 3; k++) step();

    // backpressure: two accepts then nothing until the consumer returns
    for (int i = 0; i < NREQ; i++) begin
      bus.req_data[32*i +: 32] = 32'hA500_0000 | 32'(i);
      bus.req_amount[5*i +: 5] = 5'd8;
      bus.req_left[i]          = 1'b0;
    end
    bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (obs_ready != '0) acc++;
    end
    check_eq("bp_accepts", 32'(acc), 32'd2);
    #1;
    check_eq("bp_ready_zero", 32'(bus.req_ready), 32'd0);
    check_eq("bp_hold_data", bus.rsp_data, ref_rot(32'hA500_0002, 8, 1'b0));
    check_eq("bp_hold_id", 32'(bus.rsp_id), 32'd2);
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    fires = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      fires += obs_fire;
    end
    check_eq("bp_drained", 32'(fires), 32'd2);

    // reset with both stages full
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b0;
    step();
    step();
    #1;
    check_eq("mid_busy", 32'(bus.busy), 32'd1);
    check_eq("mid_v2", 32'(bus.rsp_valid), 32'd1);
    do_reset();
    bus.req_valid = 4'b1000;
    bus.rsp_ready = 1'b1;
    #1;
    check_eq("post_rst_grant", 32'(bus.req_ready), 32'b1000);
    step();
    bus.req_valid = '0;
    for (int k = 0; k < 3; k++) step();

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      drive_random();
      step();
    end

    // fill the counter up to its wrap point
    for (int i = 0; i < NREQ; i++) bus.req_left[i] = 1'b0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 70000 && m_count != 65535; n++) step();
    #1;
    check_eq("wrap_pre", 32'(bus.op_count), 32'd65535);
    bus.req_valid = '0;
    step();
    #1;
    check_eq("wrap_zero", 32'(bus.op_count), 32'd0);
    for (int k = 0; k < 3; k++) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/rot_arbiter.md
Name: rot_arbiter

Overview:
- Shares one pipelined 32-bit barrel rotator among NREQ requesters.
- Round-robin arbitration; one grant per cycle; valid/ready handshake on every request port.
- Rotator is instantiated internally: registered input stage, registered output stage.
- Results return in order with the requester ID. Sits between the datapath clients and the rotate resource.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width, equal to ceil(log2(NREQ))

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept; one-hot or zero
- req_data  in  32*NREQ  operand; requester i uses bits [32i+31:32i]
- req_amount  in  5*NREQ  rotate amount, 0..31
- req_left  in  NREQ  1 = rotate left, 0 = rotate right
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of the requester that owns the result
- rsp_data  out  32  rotated result
- busy  out  1  any pipeline stage occupied
- op_count  out  16  completed responses; wraps 0xFFFF -> 0

Behaviour:
- Reset (asynchronous, reset_n low):
  - All pipeline valids = 0; rsp_data = 0; rsp_id = 0.
  - Round-robin pointer = 0; op_count = 0; req_ready = 0.
  - Reset mid-operation drops in-flight operations; no response is issued for them.
- Pipeline stages:
  - S1 holds operand, effective amount, ID, v1.
  - S2 holds result, ID, v2. rsp_valid = v2.
- Stall and advance:
  - stall2 = v2 && !rsp_ready.
  - adv1 = v1 && !stall2.
  - S1 can accept = !v1 || adv1.
- Arbitration (combinational, in the same cycle):
  - Only when S1 can accept, search from pointer upward with wrap and grant the first i with req_valid[i].
  - req_ready[i] = 1 for that i only.
  - Transfer = req_valid[i] && req_ready[i]. On transfer, pointer <= (i+1) mod NREQ.
  - No transfer means the pointer is unchanged.
  - req_ready does not depend on req_valid of the granted requester beyond the arbiter search. No combinational path from rsp_ready to req_ready except through the stall term.
- Effective amount:
  - Right rotate: amount as given.
  - Left rotate: (32 - amount) mod 32, computed in 5-bit arithmetic; left by 0 = right by 0.
- Rotator:
  - Combinational from S1, 5 stages (1, 2, 4, 8, 16) right-rotate conditioned on amount bits 0..4.
  - Result is loaded into S2 on adv1.
- Latency: 2 cycles from accept edge to rsp_valid, with no stall.
- Throughput: 1 op/cycle when rsp_ready is held high.
- Stall behaviour:
  - While stall2, S2 and rsp_* hold stable; S1 holds if v1.
  - Arbiter grants only if S1 is empty. At most 2 operations are in flight.
- Response transfer: on rsp_valid && rsp_ready, op_count increments by 1; v2 clears unless adv1 refills it in the same cycle.
- Simultaneous response drain and new accept in one cycle are both legal and both take effect.
- Ordering: responses leave in grant order; no reordering.
- busy = v1 || v2.
- A requester that drops req_valid before it is granted is simply not granted. No error is raised.

Test Plan:
- Single op: requester 0 sends 0x00000001, amount 1, right, rsp_ready = 1 → 2 cycles later rsp_valid = 1, rsp_data = 0x80000000, rsp_id = 0, op_count = 1.
- Left rotate: requester 2 sends 0x12345678, amount 4, left → rsp_data = 0x23456781. Amount 0, left → data unchanged 0x12345678.
- Round-robin: all 4 requesters valid continuously, pointer starts at 0 → grants 0,1,2,3,0,1 on consecutive cycles; rsp_id follows the same sequence 2 cycles later.
- Backpressure:
  - Hold rsp_ready = 0 with continuous requests → exactly 2 accepts, then req_ready = 0; rsp_data/rsp_id stay stable.
  - Release rsp_ready → results drain in order with no loss and no duplication.
- Reset mid-flight: assert reset_n low with v1 = v2 = 1 → rsp_valid, busy, req_ready and op_count go to 0 immediately. After release, the next request from requester 3 is granted first, since the pointer is 0 and only requester 3 is valid.
- Counter wrap: preload via 65535 completed ops (or force) → next response sets op_count = 0.
